// File: rtl/demux3_buf_pkg.sv
// Shared encodings and widths for the three-way buffered demux.
// Select codes are the wire encoding of in_sel; SEL_DROP discards the word.
package demux3_pkg;

  localparam int NUM_CH     = 3;
  localparam int SEL_W      = 2;
  localparam int DROP_CNT_W = 8;

  typedef enum logic [SEL_W-1:0] {
    SEL_CH0  = 2'b00,
    SEL_CH1  = 2'b01,
    SEL_CH2  = 2'b10,
    SEL_DROP = 2'b11
  } sel_e;

  function automatic logic sel_is_drop(input logic [SEL_W-1:0] sel);
    return sel == SEL_DROP;
  endfunction

endpackage

// File: rtl/demux3_buf_if.sv
// Producer/consumer bundle for demux3_buf: one input stream, three output channels.
// master = the environment driving words in and taking them out; slave = the block.
interface demux3_buf_if #(
  parameter int WIDTH = 8
);

  logic                                in_valid;
  logic                                in_ready;
  logic [WIDTH-1:0]                    in_data;
  logic [demux3_pkg::SEL_W-1:0]        in_sel;
  logic [demux3_pkg::NUM_CH-1:0]       out_valid;
  logic [demux3_pkg::NUM_CH-1:0]       out_ready;
  logic [WIDTH-1:0]                    out_data0;
  logic [WIDTH-1:0]                    out_data1;
  logic [WIDTH-1:0]                    out_data2;
  logic [demux3_pkg::DROP_CNT_W-1:0]   drop_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, drop_cnt
  );

endinterface

// File: rtl/demux3_buf_out_slot.sv
// One-entry output buffer for a single channel.
// Load wins over drain, so a full slot can refill in the cycle it empties.
module out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (drain) begin
      // data is left as-is on drain; only the valid flag clears
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule

// File: rtl/demux3_buf.sv
// Routes one input stream to three one-entry channel buffers or drops it.
// Holds only the ready decode, per-channel load enables and the drop counter.
module demux3_buf
  import demux3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  demux3_buf_if.slave  bus
);

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

  logic [NUM_CH-1:0]            w_valid;
  logic [NUM_CH-1:0]            w_drain;
  logic [NUM_CH-1:0]            w_free;
  logic [NUM_CH-1:0]            w_load;
  logic [NUM_CH-1:0][WIDTH-1:0] w_data;
  logic                         w_is_drop;
  logic                         w_xfer;
  logic                         w_ready;
  logic [DROP_CNT_W-1:0]        r_drop_cnt;

  assign w_is_drop = sel_is_drop(bus.in_sel);
  assign w_drain   = w_valid & bus.out_ready;
  // a slot can take a word if empty or if its current word leaves this cycle
  assign w_free    = ~w_valid | bus.out_ready;

  always_comb begin
    w_ready = 1'b1;
    if (!w_is_drop) w_ready = w_free[bus.in_sel];
  end

  assign w_xfer       = bus.in_valid & w_ready;
  assign bus.in_ready = w_ready;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_load[i] = w_xfer && (bus.in_sel == SEL_W'(i));

      out_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load[i]),
        .load_data (bus.in_data),
        .drain     (w_drain[i]),
        .valid     (w_valid[i]),
        .data      (w_data[i])
      );
    end
  endgenerate

  assign bus.out_valid = w_valid;
  assign bus.out_data0 = w_data[0];
  assign bus.out_data1 = w_data[1];
  assign bus.out_data2 = w_data[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_xfer && w_is_drop && (r_drop_cnt != DROP_MAX)) begin
      r_drop_cnt <= r_drop_cnt + DROP_ONE;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux3_buf.sv
// Directed bench for demux3_buf: per-channel scoreboard queues filled on accept,
// popped and compared when the channel hands its word to the consumer.
module tb_demux3_buf;

  logic clk = 1'b0;
  logic reset;

  demux3_buf_if #(.WIDTH(8)) bus ();

  demux3_buf #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         m_drop;
  int         nvec;
  int         nerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus (called just after a falling edge), check the
  // settled outputs against the model, update the model, then advance a cycle.
  task automatic step(input logic v, input logic [1:0] sel, input logic [7:0] d,
                      input logic [2:0] ordy);
    logic [2:0] mv;
    logic       exp_rdy;
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    mv      = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
    exp_rdy = (sel == 2'b11) ? 1'b1 : (!mv[sel] || ordy[sel]);
    chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(mv));
    chk("drop_cnt",  32'(bus.drop_cnt),  32'(m_drop));
    if (mv[0]) chk("out_data0", 32'(bus.out_data0), 32'(q0[0]));
    if (mv[1]) chk("out_data1", 32'(bus.out_data1), 32'(q1[0]));
    if (mv[2]) chk("out_data2", 32'(bus.out_data2), 32'(q2[0]));
    if (mv[0] && ordy[0]) void'(q0.pop_front());
    if (mv[1] && ordy[1]) void'(q1.pop_front());
    if (mv[2] && ordy[2]) void'(q2.pop_front());
    if (v && exp_rdy) begin
      case (sel)
        2'b00:   q0.push_back(d);
        2'b01:   q1.push_back(d);
        2'b10:   q2.push_back(d);
        default: if (m_drop != 255) m_drop++;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    nvec   = 0;
    nerr   = 0;
    m_drop = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'b01;
    bus.in_data   = 8'hEE;
    bus.out_ready = 3'b000;

    // reset state; in_ready reflects empty slots even while reset is high
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_drop_cnt",  32'(bus.drop_cnt),  32'h0);
    chk("rst_data0",     32'(bus.out_data0), 32'h0);
    chk("rst_data1",     32'(bus.out_data1), 32'h0);
    chk("rst_data2",     32'(bus.out_data2), 32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
    @(posedge clk);
    #1;
    chk("rst_no_xfer", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // basic routing, first accept on the first edge after reset
    step(1'b1, 2'b00, 8'h11, 3'b111);
    step(1'b1, 2'b01, 8'h22, 3'b111);
    step(1'b1, 2'b10, 8'h33, 3'b111);
    step(1'b0, 2'b00, 8'h00, 3'b111);
    step(1'b0, 2'b00, 8'h00, 3'b111);

    // back-pressure on ch1
    step(1'b1, 2'b01, 8'hA5, 3'b101);
    step(1'b1, 2'b01, 8'h5A, 3'b101);
    #1;
    chk("bp_ready_low", 32'(bus.in_ready),  32'h0);
    chk("bp_hold_data", 32'(bus.out_data1), 32'hA5);
    step(1'b1, 2'b01, 8'h5A, 3'b101);
    step(1'b1, 2'b01, 8'h5A, 3'b111);
    #1;
    chk("bp_refill", 32'(bus.out_data1), 32'h5A);
    step(1'b0, 2'b00, 8'h00, 3'b111);
    step(1'b0, 2'b00, 8'h00, 3'b111);

    // streaming on ch2 with no bubbles
    for (int k = 1; k <= 4; k++) step(1'b1, 2'b10, 8'(k), 3'b100);
    #1;
    chk("stream_last", 32'(bus.out_data2), 32'h04);
    step(1'b0, 2'b00, 8'h00, 3'b100);
    step(1'b0, 2'b00, 8'h00, 3'b100);

    // drop path and saturation
    for (int k = 0; k < 300; k++) step(1'b1, 2'b11, 8'(k), 3'b000);
    chk("drop_sat", 32'(bus.drop_cnt), 32'd255);

    // ch0 stalled on 0x77 while ch1 streams past it
    step(1'b1, 2'b00, 8'h77, 3'b000);
    for (int k = 0; k < 4; k++) step(1'b1, 2'b01, 8'hC0 + 8'(k), 3'b010);
    step(1'b1, 2'b00, 8'h78, 3'b010);
    step(1'b0, 2'b00, 8'h00, 3'b010);
    chk("stall_data0",  32'(bus.out_data0),    32'h77);
    chk("stall_valid0", 32'(bus.out_valid[0]), 32'h1);

    // async reset mid-cycle with a word offered
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'b10;
    bus.in_data   = 8'h3C;
    bus.out_ready = 3'b000;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_drop_cnt",  32'(bus.drop_cnt),  32'h0);
    chk("arst_data0",     32'(bus.out_data0), 32'h0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'h1);
    q0.delete();
    q1.delete();
    q2.delete();
    m_drop = 0;
    @(posedge clk);
    #1;
    chk("arst_no_xfer", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    step(1'b1, 2'b00, 8'h99, 3'b001);
    step(1'b1, 2'b11, 8'h00, 3'b001);
    step(1'b0, 2'b00, 8'h00, 3'b001);
    chk("post_rst_drop", 32'(bus.drop_cnt), 32'h1);

    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      nvec++;
      nerr++;
      $error("FAIL scoreboard_drain: observed %0d %0d %0d words left, expected 0",
             q0.size(), q1.size(), q2.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/demux3_buf.md
DEMUX3_BUF -- requirements
Module: demux3_buf

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the input and of each output channel.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  producer offers a word this cycle.
REQ-005 in_ready  output  1  block accepts the offered word this cycle.
REQ-006 in_data  input  WIDTH  word to route.
REQ-007 in_sel  input  2  destination: 00 = ch0, 01 = ch1, 10 = ch2, 11 = drop.
REQ-008 out_valid  output  3  bit i high = channel i holds a word.
REQ-009 out_ready  input  3  bit i high = consumer i takes the word this cycle.
REQ-010 out_data0, out_data1, out_data2  output  WIDTH each  held word for ch0, ch1, ch2.
REQ-011 drop_cnt  output  8  saturating count of words accepted with in_sel = 11.

Function
REQ-012 Transfer rules: an input transfer occurs when in_valid and in_ready are both high; an output transfer on channel i occurs when out_valid[i] and out_ready[i] are both high.
REQ-013 Channel buffering: each channel has a one-entry buffer; a word accepted in cycle N appears on its channel in cycle N+1 (latency 1).
REQ-014 in_ready for in_sel 0..2 is high when the selected slot is empty or draining: !out_valid[sel] || out_ready[sel].
REQ-015 in_ready for in_sel = 11 is high unconditionally.
REQ-016 in_ready is combinational from in_sel, out_valid and out_ready; in_ready is independent of in_valid.
REQ-017 Accept: on an input transfer with in_sel = i < 3, slot i loads in_data and out_valid[i] is high next cycle.
REQ-018 Simultaneous load and drain on the same slot: the slot takes the new word and out_valid stays high (full throughput, no bubble).
REQ-019 Drain without load: out_valid[i] clears next cycle.
REQ-020 Stall: while out_valid[i] is high and out_ready[i] is low, out_data_i and out_valid[i] hold stable.
REQ-021 Non-selected slots are unaffected by an input transfer; each channel drains independently and concurrently.
REQ-022 Drop: an input transfer with in_sel = 11 discards the word and increments drop_cnt.
REQ-023 drop_cnt saturates at 255.
REQ-024 in_data and in_sel are ignored when in_valid is low.
REQ-025 out_data_i is don't-care while out_valid[i] is low, but holds the last loaded value (no clearing on drain).

Reset
REQ-026 Reset clears out_valid to 000, all out_data to 0 and drop_cnt to 0, asynchronously.
REQ-027 A word in flight when reset asserts is lost; no transfer completes while reset is high.
REQ-028 The first accept is possible in the first rising edge after reset deasserts.
REQ-029 While reset is high, in_ready follows REQ-014 and REQ-015 with all slots empty.

Structure
REQ-030 Shared package demux3_pkg holds the select encodings SEL_CH0, SEL_CH1, SEL_CH2, SEL_DROP and the constant DROP_CNT_W = 8.
REQ-031 The one-entry slot is the sub-module out_slot (parameter WIDTH; ports clk, reset, load, load_data, drain, valid, data), instantiated three times.
REQ-032 The top level contains only the in_ready decode, the load-enable decode and the drop counter.

Verification
REQ-033 Basic routing: after reset, send 0x11/sel 00, 0x22/sel 01, 0x33/sel 10 with all out_ready high -> each word appears one cycle later on ch0, ch1 and ch2 respectively, with matching out_valid pulses.
REQ-034 Back-pressure: out_ready[1] = 0; send 0xA5/sel 01 then 0x5A/sel 01 -> in_ready drops on the second offer, out_data1 holds 0xA5; raise out_ready[1] -> 0xA5 drains, 0x5A is accepted in the same cycle and appears next cycle.
REQ-035 Streaming: ch2 out_ready held high; 4 back-to-back words 0x01..0x04 on sel 10 -> in_ready stays high and out_data2 shows 0x01..0x04 on consecutive cycles with no bubble.
REQ-036 Drop and saturation: 300 words with sel 11 -> in_ready always high, no out_valid activity, drop_cnt reads 255.
REQ-037 Independence and reset: ch0 stalled holding 0x77 while ch1 streams -> ch1 unaffected; assert reset mid-cycle -> out_valid = 000 and drop_cnt = 0 immediately, without waiting for a clock edge.
